// File: rtl/sr_pipe_fde.sv
// Fetch / decode / execute front end of the schoolRISCV pipeline with F/D, D/E and E/W registers.
// Optional macro SR_PIPE_SRL_SLTU_EN adds the srl and sltu instructions to decode and the ALU.
module sr_pipe_fde (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic [31:0] pc_i,
  output logic [31:0] imAddr,
  input  logic [31:0] imData,
  output logic [31:0] pc_fd,
  output logic [31:0] pcPlus4_fd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        branch_d,
  input  logic [31:0] srcA_i,
  input  logic [31:0] srcB_i,
  output logic        wdSrc_e,
  output logic        regWrite_e,
  output logic        branch_e,
  output logic        condZero_e,
  output logic        aluZero_e,
  output logic [31:0] aluResult_e,
  output logic [31:0] immU_e,
  output logic [31:0] pcBranch_e,
  output logic [31:0] pcPlus4_e,
  output logic [4:0]  rd_e
);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SRL  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ---------------- F/D ----------------
  logic [31:0] instr_fd_reg;
  logic [31:0] pc_fd_reg;
  logic [31:0] pcplus4_fd_reg;

  assign imAddr = {2'b00, pc_i[31:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_fd_reg   <= 32'd0;
      pc_fd_reg      <= 32'd0;
      pcplus4_fd_reg <= 32'd0;
    end else if (!freeze) begin
      instr_fd_reg   <= imData;
      pc_fd_reg      <= pc_i;
      pcplus4_fd_reg <= pc_i + 32'd4;
    end
  end

  assign pc_fd      = pc_fd_reg;
  assign pcPlus4_fd = pcplus4_fd_reg;

  // ---------------- Decode ----------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immi_next;
  logic [31:0] immu_next;
  logic [31:0] immb;
  logic [31:0] pcbranch_next;
  logic        wdsrc_next;
  logic        regwrite_next;
  logic        branch_next;
  logic        condzero_next;
  logic        alusrc_next;
  logic [2:0]  aluctrl_next;

  assign opcode = instr_fd_reg[6:0];
  assign funct3 = instr_fd_reg[14:12];
  assign funct7 = instr_fd_reg[31:25];
  assign rs1    = instr_fd_reg[19:15];
  assign rs2    = instr_fd_reg[24:20];

  assign immi_next = {{20{instr_fd_reg[31]}}, instr_fd_reg[31:20]};
  assign immu_next = {instr_fd_reg[31:12], 12'b0};
  assign immb      = {{20{instr_fd_reg[31]}}, instr_fd_reg[7], instr_fd_reg[30:25],
                      instr_fd_reg[11:8], 1'b0};
  assign pcbranch_next = pc_fd_reg + immb;

  always_comb begin
    wdsrc_next    = 1'b0;
    regwrite_next = 1'b0;
    branch_next   = 1'b0;
    condzero_next = 1'b0;
    alusrc_next   = 1'b0;
    aluctrl_next  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              aluctrl_next  = ALU_ADD;
              regwrite_next = 1'b1;
              wdsrc_next    = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              aluctrl_next  = ALU_SUB;
              regwrite_next = 1'b1;
              wdsrc_next    = 1'b1;
            end
          end
          3'b110: begin
            if (funct7 == 7'b0000000) begin
              aluctrl_next  = ALU_OR;
              regwrite_next = 1'b1;
              wdsrc_next    = 1'b1;
            end
          end
`ifdef SR_PIPE_SRL_SLTU_EN
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              aluctrl_next  = ALU_SRL;
              regwrite_next = 1'b1;
              wdsrc_next    = 1'b1;
            end
          end
          3'b011: begin
            if (funct7 == 7'b0000000) begin
              aluctrl_next  = ALU_SLTU;
              regwrite_next = 1'b1;
              wdsrc_next    = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          aluctrl_next  = ALU_ADD;
          alusrc_next   = 1'b1;
          regwrite_next = 1'b1;
          wdsrc_next    = 1'b1;
        end
      end
      OP_LUI: begin
        regwrite_next = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          branch_next   = 1'b1;
          condzero_next = (funct3 == 3'b000);
          aluctrl_next  = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  assign branch_d = branch_next;

  // ---------------- D/E ----------------
  logic        wdsrc_de_reg;
  logic        regwrite_de_reg;
  logic        branch_de_reg;
  logic        condzero_de_reg;
  logic        alusrc_de_reg;
  logic [2:0]  aluctrl_de_reg;
  logic [4:0]  rd_de_reg;
  logic [31:0] immi_de_reg;
  logic [31:0] immu_de_reg;
  logic [31:0] pcbranch_de_reg;
  logic [31:0] pcplus4_de_reg;
  logic [31:0] srca_de_reg;
  logic [31:0] srcb_de_reg;

  // A stall loads an all-zero bubble so the downstream stages see a clean nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdsrc_de_reg    <= 1'b0;
      regwrite_de_reg <= 1'b0;
      branch_de_reg   <= 1'b0;
      condzero_de_reg <= 1'b0;
      alusrc_de_reg   <= 1'b0;
      aluctrl_de_reg  <= ALU_ADD;
      rd_de_reg       <= 5'd0;
      immi_de_reg     <= 32'd0;
      immu_de_reg     <= 32'd0;
      pcbranch_de_reg <= 32'd0;
      pcplus4_de_reg  <= 32'd0;
      srca_de_reg     <= 32'd0;
      srcb_de_reg     <= 32'd0;
    end else if (freeze) begin
      wdsrc_de_reg    <= 1'b0;
      regwrite_de_reg <= 1'b0;
      branch_de_reg   <= 1'b0;
      condzero_de_reg <= 1'b0;
      alusrc_de_reg   <= 1'b0;
      aluctrl_de_reg  <= ALU_ADD;
      rd_de_reg       <= 5'd0;
      immi_de_reg     <= 32'd0;
      immu_de_reg     <= 32'd0;
      pcbranch_de_reg <= 32'd0;
      pcplus4_de_reg  <= 32'd0;
      srca_de_reg     <= 32'd0;
      srcb_de_reg     <= 32'd0;
    end else begin
      wdsrc_de_reg    <= wdsrc_next;
      regwrite_de_reg <= regwrite_next;
      branch_de_reg   <= branch_next;
      condzero_de_reg <= condzero_next;
      alusrc_de_reg   <= alusrc_next;
      aluctrl_de_reg  <= aluctrl_next;
      rd_de_reg       <= instr_fd_reg[11:7];
      immi_de_reg     <= immi_next;
      immu_de_reg     <= immu_next;
      pcbranch_de_reg <= pcbranch_next;
      pcplus4_de_reg  <= pcplus4_fd_reg;
      srca_de_reg     <= srcA_i;
      srcb_de_reg     <= srcB_i;
    end
  end

  // ---------------- Execute ----------------
  logic [31:0] alu_b;
  logic [31:0] alu_result_next;

  assign alu_b = alusrc_de_reg ? immi_de_reg : srcb_de_reg;

  always_comb begin
    alu_result_next = srca_de_reg + alu_b;
    case (aluctrl_de_reg)
      ALU_SUB:  alu_result_next = srca_de_reg - alu_b;
      ALU_OR:   alu_result_next = srca_de_reg | alu_b;
`ifdef SR_PIPE_SRL_SLTU_EN
      ALU_SRL:  alu_result_next = srca_de_reg >> alu_b[4:0];
      ALU_SLTU: alu_result_next = {31'b0, (srca_de_reg < alu_b)};
`endif
      default:  alu_result_next = srca_de_reg + alu_b;
    endcase
  end

  // ---------------- E/W ----------------
  logic        wdsrc_ew_reg;
  logic        regwrite_ew_reg;
  logic        branch_ew_reg;
  logic        condzero_ew_reg;
  logic        aluzero_ew_reg;
  logic [31:0] aluresult_ew_reg;
  logic [31:0] immu_ew_reg;
  logic [31:0] pcbranch_ew_reg;
  logic [31:0] pcplus4_ew_reg;
  logic [4:0]  rd_ew_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdsrc_ew_reg     <= 1'b0;
      regwrite_ew_reg  <= 1'b0;
      branch_ew_reg    <= 1'b0;
      condzero_ew_reg  <= 1'b0;
      aluzero_ew_reg   <= 1'b0;
      aluresult_ew_reg <= 32'd0;
      immu_ew_reg      <= 32'd0;
      pcbranch_ew_reg  <= 32'd0;
      pcplus4_ew_reg   <= 32'd0;
      rd_ew_reg        <= 5'd0;
    end else begin
      wdsrc_ew_reg     <= wdsrc_de_reg;
      regwrite_ew_reg  <= regwrite_de_reg;
      branch_ew_reg    <= branch_de_reg;
      condzero_ew_reg  <= condzero_de_reg;
      aluzero_ew_reg   <= (alu_result_next == 32'd0);
      aluresult_ew_reg <= alu_result_next;
      immu_ew_reg      <= immu_de_reg;
      pcbranch_ew_reg  <= pcbranch_de_reg;
      pcplus4_ew_reg   <= pcplus4_de_reg;
      rd_ew_reg        <= rd_de_reg;
    end
  end

  assign wdSrc_e     = wdsrc_ew_reg;
  assign regWrite_e  = regwrite_ew_reg;
  assign branch_e    = branch_ew_reg;
  assign condZero_e  = condzero_ew_reg;
  assign aluZero_e   = aluzero_ew_reg;
  assign aluResult_e = aluresult_ew_reg;
  assign immU_e      = immu_ew_reg;
  assign pcBranch_e  = pcbranch_ew_reg;
  assign pcPlus4_e   = pcplus4_ew_reg;
  assign rd_e        = rd_ew_reg;

endmodule

// File: tb/tb_sr_pipe_fde.sv
// Bench for sr_pipe_fde: directed cases then random instruction streams against an
// instruction-level reference model that tracks what sits in each pipeline slot.
module tb_sr_pipe_fde;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic [31:0] pc_i, imData, srcA_i, srcB_i;
  logic [31:0] imAddr, pc_fd, pcPlus4_fd;
  logic [4:0]  rs1, rs2, rd_e;
  logic        branch_d, wdSrc_e, regWrite_e, branch_e, condZero_e, aluZero_e;
  logic [31:0] aluResult_e, immU_e, pcBranch_e, pcPlus4_e;

  int checks = 0;
  int errors = 0;

  sr_pipe_fde dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .pc_i(pc_i), .imAddr(imAddr),
    .imData(imData), .pc_fd(pc_fd), .pcPlus4_fd(pcPlus4_fd), .rs1(rs1), .rs2(rs2),
    .branch_d(branch_d), .srcA_i(srcA_i), .srcB_i(srcB_i), .wdSrc_e(wdSrc_e),
    .regWrite_e(regWrite_e), .branch_e(branch_e), .condZero_e(condZero_e),
    .aluZero_e(aluZero_e), .aluResult_e(aluResult_e), .immU_e(immU_e),
    .pcBranch_e(pcBranch_e), .pcPlus4_e(pcPlus4_e), .rd_e(rd_e)
  );

  always #5 clk = ~clk;

  // An instruction slot: the raw word, its PC values and the operands it was given.
  typedef struct packed {
    logic [31:0] instr, pc, pc4, a, b;
  } slot_t;

  typedef struct packed {
    logic        wd, rw, br, cz, az;
    logic [31:0] res, immu, pcb, pc4;
    logic [4:0]  rd;
  } ew_t;

  slot_t m_fd, m_de;
  ew_t   m_ew;

  // Architectural meaning of one instruction given its operand values.
  function automatic ew_t run_instr(input slot_t s);
    ew_t r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_b;
    op = s.instr[6:0];
    f3 = s.instr[14:12];
    f7 = s.instr[31:25];
    imm_i = {{20{s.instr[31]}}, s.instr[31:20]};
    imm_b = {{20{s.instr[31]}}, s.instr[7], s.instr[30:25], s.instr[11:8], 1'b0};
    r = '0;
    r.res = s.a + s.b;
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin
      r.rw = 1; r.wd = 1; r.res = s.a + s.b;
    end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
      r.rw = 1; r.wd = 1; r.res = s.a - s.b;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin
      r.rw = 1; r.wd = 1; r.res = s.a | s.b;
`ifdef SR_PIPE_SRL_SLTU_EN
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd5) begin
      r.rw = 1; r.wd = 1; r.res = s.a >> s.b[4:0];
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd3) begin
      r.rw = 1; r.wd = 1; r.res = (s.a < s.b) ? 32'd1 : 32'd0;
`endif
    end else if (op == 7'h13 && f3 == 3'd0) begin
      r.rw = 1; r.wd = 1; r.res = s.a + imm_i;
    end else if (op == 7'h37) begin
      r.rw = 1;
    end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
      r.br = 1; r.cz = (f3 == 3'd0); r.res = s.a - s.b;
    end
    r.az   = (r.res == 32'd0);
    r.immu = {s.instr[31:12], 12'b0};
    r.pcb  = s.pc + imm_b;
    r.pc4  = s.pc4;
    r.rd   = s.instr[11:7];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    ew_t d;
    d = run_instr(m_fd);
    check("pc_fd", pc_fd, m_fd.pc);
    check("pcPlus4_fd", pcPlus4_fd, m_fd.pc4);
    check("rs1", {27'd0, rs1}, {27'd0, m_fd.instr[19:15]});
    check("rs2", {27'd0, rs2}, {27'd0, m_fd.instr[24:20]});
    check("branch_d", {31'd0, branch_d}, {31'd0, d.br});
    check("wdSrc_e", {31'd0, wdSrc_e}, {31'd0, m_ew.wd});
    check("regWrite_e", {31'd0, regWrite_e}, {31'd0, m_ew.rw});
    check("branch_e", {31'd0, branch_e}, {31'd0, m_ew.br});
    check("condZero_e", {31'd0, condZero_e}, {31'd0, m_ew.cz});
    check("aluZero_e", {31'd0, aluZero_e}, {31'd0, m_ew.az});
    check("aluResult_e", aluResult_e, m_ew.res);
    check("immU_e", immU_e, m_ew.immu);
    check("pcBranch_e", pcBranch_e, m_ew.pcb);
    check("pcPlus4_e", pcPlus4_e, m_ew.pc4);
    check("rd_e", {27'd0, rd_e}, {27'd0, m_ew.rd});
  endtask

  // One clock: a/b are the operands for the instruction currently held in F/D.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic frz);
    pc_i = pc; imData = instr; srcA_i = a; srcB_i = b; freeze = frz;
    #1;
    check("imAddr", imAddr, {2'b00, pc[31:2]});
    @(posedge clk);
    m_ew = run_instr(m_de);
    if (frz) m_de = '0;
    else     m_de = '{instr: m_fd.instr, pc: m_fd.pc, pc4: m_fd.pc4, a: a, b: b};
    if (!frz) m_fd = '{instr: instr, pc: pc, pc4: pc + 32'd4, a: 32'd0, b: 32'd0};
    @(negedge clk);
    check_state();
    $display("txn pc=%h instr=%h a=%h b=%h frz=%0d -> rw=%0d rd=%0d res=%h",
             pc, instr, a, b, frz, regWrite_e, rd_e, aluResult_e);
  endtask

  task automatic model_reset();
    m_fd = '0; m_de = '0; m_ew = '0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] ra, rb, rd;
    ra = 5'($urandom); rb = 5'($urandom); rd = 5'($urandom);
    case ($urandom_range(0, 10))
      0: return {7'h00, rb, ra, 3'd0, rd, 7'h33};
      1: return {7'h20, rb, ra, 3'd0, rd, 7'h33};
      2: return {7'h00, rb, ra, 3'd6, rd, 7'h33};
      3: return {7'h00, rb, ra, 3'd5, rd, 7'h33};
      4: return {7'h00, rb, ra, 3'd3, rd, 7'h33};
      5: return {12'($urandom), ra, 3'd0, rd, 7'h13};
      6: return {20'($urandom), rd, 7'h37};
      7: return {7'($urandom), rb, ra, 3'd0, 5'($urandom), 7'h63};
      8: return {7'($urandom), rb, ra, 3'd1, 5'($urandom), 7'h63};
      9: return {7'($urandom), rb, ra, 3'($urandom), rd, 7'h33};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] LUI  = 32'h1234_52B7;
  localparam logic [31:0] BEQ  = 32'h0020_8463;
  localparam logic [31:0] BNE  = 32'h0020_9463;
  localparam logic [31:0] SLTU = 32'h0031_30B3;

  initial begin
    logic [31:0] pc, a, b;
    logic exp_sltu_rw;
    logic [31:0] exp_sltu_res;

    // Reset held across edges with freeze asserted: everything stays clear.
    rst_n = 1'b0; freeze = 1'b1; pc_i = 32'h40; imData = ADDI; srcA_i = 32'd3; srcB_i = 32'd4;
    model_reset();
    repeat (2) @(negedge clk);
    check_state();
    rst_n = 1'b1;

    step(ADDI, 32'h0, 32'd0, 32'd0, 1'b0);
    step(ADDI, 32'h4, 32'd0, 32'd0, 1'b0);
    step(ADDI, 32'h8, 32'd0, 32'd0, 1'b0);
    check("addi_rw", {31'd0, regWrite_e}, 32'd1);
    check("addi_res", aluResult_e, 32'd0);

    step(ADD, 32'h20, 32'd0, 32'd0, 1'b0);
    check("add_rs1", {27'd0, rs1}, 32'd1);
    step(NOP, 32'h24, 32'd5, 32'd7, 1'b0);
    step(NOP, 32'h28, 32'd0, 32'd0, 1'b0);
    check("add_res", aluResult_e, 32'd12);
    check("add_rd", {27'd0, rd_e}, 32'd3);

    step(LUI, 32'h30, 32'd0, 32'd0, 1'b0);
    step(NOP, 32'h34, 32'd1, 32'd2, 1'b0);
    step(NOP, 32'h38, 32'd0, 32'd0, 1'b0);
    check("lui_immU", immU_e, 32'h1234_5000);
    check("lui_wdsrc", {31'd0, wdSrc_e}, 32'd0);

    step(BEQ, 32'h10, 32'd0, 32'd0, 1'b0);
    check("beq_branch_d", {31'd0, branch_d}, 32'd1);
    step(BNE, 32'h14, 32'd9, 32'd9, 1'b0);
    step(NOP, 32'h18, 32'd9, 32'd9, 1'b0);
    check("beq_pcb", pcBranch_e, 32'h18);
    check("beq_pc4", pcPlus4_e, 32'h14);
    check("beq_cz", {31'd0, condZero_e}, 32'd1);
    step(NOP, 32'h1C, 32'd0, 32'd0, 1'b0);
    check("bne_cz", {31'd0, condZero_e}, 32'd0);
    check("bne_az", {31'd0, aluZero_e}, 32'd1);

    step(ADD, 32'h40, 32'd0, 32'd0, 1'b0);
    step(NOP, 32'h44, 32'd5, 32'd7, 1'b1);
    check("frz1_pc", pc_fd, 32'h40);
    step(NOP, 32'h48, 32'd1, 32'd1, 1'b1);
    check("frz2_pc", pc_fd, 32'h40);
    check("bubble1_rw", {31'd0, regWrite_e}, 32'd0);
    step(NOP, 32'h44, 32'd5, 32'd7, 1'b0);
    check("bubble2_br", {31'd0, branch_e}, 32'd0);
    step(NOP, 32'h48, 32'd0, 32'd0, 1'b0);
    check("held_res", aluResult_e, 32'd12);

`ifdef SR_PIPE_SRL_SLTU_EN
    exp_sltu_rw = 1'b1; exp_sltu_res = 32'd1;
`else
    exp_sltu_rw = 1'b0; exp_sltu_res = 32'd7;
`endif
    step(SLTU, 32'h50, 32'd0, 32'd0, 1'b0);
    step(NOP, 32'h54, 32'd3, 32'd4, 1'b0);
    step(NOP, 32'h58, 32'd0, 32'd0, 1'b0);
    check("sltu_rw", {31'd0, regWrite_e}, {31'd0, exp_sltu_rw});
    check("sltu_res", aluResult_e, exp_sltu_res);

    // Random streams with stalls, plus one asynchronous reset mid-cycle.
    pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = $urandom_range(0, 40); b = $urandom_range(0, 40); end
        default: b = $urandom;
      endcase
      step(rand_instr(), pc, a, b, ($urandom_range(0, 4) == 0));
      pc = pc + ($urandom_range(0, 5) == 0 ? $urandom : 32'd4);
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
